wave_monitor: RTL and testbench



---
 rtl/wave_monitor.sv | 142 ++++++++++++++
 tb/tb_wave_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_monitor.sv
// Sample-stream analyzer: rising mid-scale crossings with hysteresis, per-cycle
// period and min/max, completed-cycle count with optional burst target.
//
// state   | meaning
// IDLE    | stopped; results held, waiting for enable
// ARMED   | running, waiting for the first rising crossing
// MEASURE | timing a cycle and tracking its min/max
// DONE    | target cycle count reached; results frozen until enable low
module wave_monitor #(
   parameter int WIDTH    = 12,
   parameter int MID      = 2048,
   parameter int HYST     = 64,
   parameter int PERIOD_W = 32,
   parameter int TIMEOUT  = 16777216
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [WIDTH-1:0]    sample,
   input  logic                sample_valid,
   input  logic [15:0]         target_cycles,
   output logic [PERIOD_W-1:0] period,
   output logic [WIDTH-1:0]    min_val,
   output logic [WIDTH-1:0]    max_val,
   output logic                meas_valid,
   output logic [15:0]         cycle_count,
   output logic                done,
   output logic                stall
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] MEASURE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   // thresholds carry one extra bit so MID+HYST cannot wrap at full scale
   localparam logic [WIDTH:0]    LO_TH  = (WIDTH+1)'(MID - HYST);
   localparam logic [WIDTH:0]    HI_TH  = (WIDTH+1)'(MID + HYST);
   localparam logic [PERIOD_W-1:0] TO_VAL = PERIOD_W'(TIMEOUT);

   logic [1:0]          state;
   logic [15:0]         target_q;
   logic [PERIOD_W-1:0] per_cnt;
   logic [WIDTH-1:0]    trk_min;
   logic [WIDTH-1:0]    trk_max;
   logic                low_flag;

   logic [WIDTH:0]      sample_ext;
   logic                is_low;
   logic                is_high;
   logic                rise;
   logic [PERIOD_W-1:0] per_inc;
   logic [15:0]         cycle_inc;
   logic [WIDTH-1:0]    merged_min;
   logic [WIDTH-1:0]    merged_max;

   always_comb begin
      sample_ext = {1'b0, sample};
      is_low     = sample_valid && (sample_ext <= LO_TH);
      is_high    = sample_valid && (sample_ext >= HI_TH);
      rise       = is_high && low_flag;
      per_inc    = (per_cnt == {PERIOD_W{1'b1}}) ? per_cnt : per_cnt + 1'b1;
      cycle_inc  = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
      merged_min = (sample < trk_min) ? sample : trk_min;
      merged_max = (sample > trk_max) ? sample : trk_max;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         target_q    <= '0;
         per_cnt     <= '0;
         trk_min     <= '0;
         trk_max     <= '0;
         low_flag    <= 1'b0;
         period      <= '0;
         min_val     <= '0;
         max_val     <= '0;
         meas_valid  <= 1'b0;
         cycle_count <= '0;
         done        <= 1'b0;
         stall       <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (!enable) begin
            state       <= IDLE;
            cycle_count <= '0;
            done        <= 1'b0;
            stall       <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  target_q <= target_cycles;
                  per_cnt  <= '0;
                  low_flag <= 1'b0;
                  state    <= ARMED;
               end
               ARMED: begin
                  if (is_low) low_flag <= 1'b1;
                  else if (rise) low_flag <= 1'b0;
                  if (rise) begin
                     state   <= MEASURE;
                     per_cnt <= PERIOD_W'(1);
                     trk_min <= sample;
                     trk_max <= sample;
                  end else begin
                     per_cnt <= per_inc;
                     if (per_inc == TO_VAL) stall <= 1'b1;
                  end
               end
               MEASURE: begin
                  if (is_low) low_flag <= 1'b1;
                  else if (rise) low_flag <= 1'b0;
                  if (rise) begin
                     period      <= per_cnt;
                     min_val     <= merged_min;
                     max_val     <= merged_max;
                     meas_valid  <= 1'b1;
                     cycle_count <= cycle_inc;
                     per_cnt     <= PERIOD_W'(1);
                     trk_min     <= sample;
                     trk_max     <= sample;
                     if ((target_q != 16'd0) && (cycle_inc == target_q)) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     per_cnt <= per_inc;
                     if (per_inc == TO_VAL) stall <= 1'b1;
                     if (sample_valid) begin
                        trk_min <= merged_min;
                        trk_max <= merged_max;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wave_monitor.sv
// Directed bench for wave_monitor: a per-clock vector table for the crossing
// thresholds and burst target, plus stream sequences for the multi-cycle cases.
module tb_wave_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [11:0] sample;
   logic        sample_valid;
   logic [15:0] target_cycles;
   logic [31:0] period;
   logic [11:0] min_val;
   logic [11:0] max_val;
   logic        meas_valid;
   logic [15:0] cycle_count;
   logic        done;
   logic        stall;

   int n_checks = 0;
   int n_pass   = 0;

   wave_monitor #(.TIMEOUT(256)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .sample        (sample),
      .sample_valid  (sample_valid),
      .target_cycles (target_cycles),
      .period        (period),
      .min_val       (min_val),
      .max_val       (max_val),
      .meas_valid    (meas_valid),
      .cycle_count   (cycle_count),
      .done          (done),
      .stall         (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [11:0] s;
      logic        v;
      logic [15:0] tgt;
      logic        mv;
      logic [31:0] per;
      logic [11:0] mn;
      logic [11:0] mx;
      logic [15:0] cc;
      logic        dn;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(logic en, int s, logic v, int tgt, logic mv,
                               int per, int mn, int mx, int cc, logic dn);
      vec_t r;
      r.en = en; r.s = 12'(s); r.v = v; r.tgt = 16'(tgt); r.mv = mv;
      r.per = 32'(per); r.mn = 12'(mn); r.mx = 12'(mx); r.cc = 16'(cc); r.dn = dn;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] sq(int i);
      return ((i % 100) < 50) ? 12'd0 : 12'd4095;
   endfunction

   function automatic logic [11:0] tri_s(int i);
      int t;
      t = i % 256;
      return (t < 128) ? 12'(t * 32) : 12'((255 - t) * 32);
   endfunction

   initial begin
      int pulses;
      int first_idx;
      int any_mv;

      rst_n = 1'b0; enable = 1'b0; sample = '0; sample_valid = 1'b1; target_cycles = '0;

      // thresholds, invalid-sample rejection, target latching and the done edge
      vecs[0]  = mk(1, 2048, 1, 2, 0, 0, 0,    0,    0, 0);
      vecs[1]  = mk(1, 1984, 1, 2, 0, 0, 0,    0,    0, 0);
      vecs[2]  = mk(1, 2112, 1, 2, 0, 0, 0,    0,    0, 0);
      vecs[3]  = mk(1, 1000, 1, 2, 0, 0, 0,    0,    0, 0);
      vecs[4]  = mk(1, 4000, 0, 2, 0, 0, 0,    0,    0, 0);
      vecs[5]  = mk(1, 2111, 1, 2, 0, 0, 0,    0,    0, 0);
      vecs[6]  = mk(1, 2112, 1, 2, 1, 4, 1000, 2112, 1, 0);
      vecs[7]  = mk(1, 1985, 1, 0, 0, 4, 1000, 2112, 1, 0);
      vecs[8]  = mk(1, 4095, 1, 0, 0, 4, 1000, 2112, 1, 0);
      vecs[9]  = mk(1, 1984, 1, 0, 0, 4, 1000, 2112, 1, 0);
      vecs[10] = mk(1, 2200, 1, 0, 1, 4, 1984, 4095, 2, 1);
      vecs[11] = mk(1, 0,    1, 0, 0, 4, 1984, 4095, 2, 1);
      vecs[12] = mk(1, 4095, 1, 0, 0, 4, 1984, 4095, 2, 1);
      vecs[13] = mk(0, 2048, 1, 0, 0, 4, 1984, 4095, 0, 0);

      #22;
      chk("reset_period", period, 32'd0);
      chk("reset_minmax", {8'd0, min_val, max_val}, 32'd0);
      chk("reset_flags", {28'd0, meas_valid, done, stall, 1'b0}, 32'd0);
      chk("reset_cycle_count", 32'(cycle_count), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         enable = vecs[i].en; sample = vecs[i].s; sample_valid = vecs[i].v;
         target_cycles = vecs[i].tgt;
         tick();
         chk($sformatf("vec%0d_meas_valid", i), 32'(meas_valid), 32'(vecs[i].mv));
         chk($sformatf("vec%0d_period", i), period, vecs[i].per);
         chk($sformatf("vec%0d_min", i), 32'(min_val), 32'(vecs[i].mn));
         chk($sformatf("vec%0d_max", i), 32'(max_val), 32'(vecs[i].mx));
         chk($sformatf("vec%0d_cycle_count", i), 32'(cycle_count), 32'(vecs[i].cc));
         chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
         chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      end

      // square stream, period 100
      sample_valid = 1'b1; target_cycles = 16'd0; enable = 1'b1; sample = '0;
      tick();
      pulses = 0;
      for (int i = 0; i < 500; i++) begin
         sample = sq(i);
         tick();
         if (meas_valid) begin
            pulses++;
            chk("sq_period", period, 32'd100);
            chk("sq_min", 32'(min_val), 32'd0);
            chk("sq_max", 32'(max_val), 32'd4095);
            chk("sq_cycle_count", 32'(cycle_count), 32'(pulses));
         end
      end
      chk("sq_pulses", 32'(pulses), 32'd4);
      chk("sq_stall", 32'(stall), 32'd0);

      // in-band samples only
      enable = 1'b0; tick();
      enable = 1'b1; sample = 12'd2000; tick();
      any_mv = 0;
      for (int i = 0; i < 1000; i++) begin
         sample = (i % 2 == 1) ? 12'd2100 : 12'd2000;
         tick();
         if (meas_valid) any_mv++;
      end
      chk("hyst_no_meas", 32'(any_mv), 32'd0);
      chk("hyst_cycle_count", 32'(cycle_count), 32'd0);
      chk("hyst_stall", 32'(stall), 32'd1);

      // burst of 3 on a 256-clock triangle
      enable = 1'b0; tick();
      chk("disable_clears_stall", 32'(stall), 32'd0);
      target_cycles = 16'd3; enable = 1'b1; sample = '0; tick();
      target_cycles = 16'd5;
      pulses = 0;
      for (int i = 0; i < 6 * 256; i++) begin
         sample = tri_s(i);
         tick();
         if (meas_valid) begin
            pulses++;
            chk("tri_period", period, 32'd256);
            chk("tri_minmax", {8'd0, min_val, max_val}, {8'd0, 12'd0, 12'd4064});
            chk("tri_cycle_count", 32'(cycle_count), 32'(pulses));
            chk("tri_done_edge", 32'(done), (pulses == 3) ? 32'd1 : 32'd0);
         end
      end
      chk("tri_pulses", 32'(pulses), 32'd3);
      chk("tri_done_held", 32'(done), 32'd1);
      chk("tri_count_held", 32'(cycle_count), 32'd3);
      enable = 1'b0; tick();
      chk("tri_off_done", 32'(done), 32'd0);
      chk("tri_off_count", 32'(cycle_count), 32'd0);
      chk("tri_off_period_kept", period, 32'd256);

      // valid on every other clock, in-band filler on the gaps
      target_cycles = 16'd0; enable = 1'b1; sample = '0; tick();
      pulses = 0;
      for (int j = 0; j < 800; j++) begin
         sample_valid = (j % 2 == 0);
         sample = sample_valid ? sq(j / 2) : 12'h800;
         tick();
         if (meas_valid) begin
            pulses++;
            chk("gap_period", period, 32'd200);
            chk("gap_minmax", {8'd0, min_val, max_val}, {8'd0, 12'd0, 12'd4095});
         end
      end
      chk("gap_pulses", 32'(pulses), 32'd3);
      chk("gap_stall", 32'(stall), 32'd0);
      sample_valid = 1'b1;

      // timeout while armed, then measurements resume with stall sticky
      enable = 1'b0; tick();
      enable = 1'b1; sample = 12'd2048; tick();
      for (int i = 0; i < 255; i++) tick();
      chk("to_before", 32'(stall), 32'd0);
      tick();
      chk("to_at", 32'(stall), 32'd1);
      pulses = 0;
      for (int i = 0; i < 400; i++) begin
         sample = sq(i);
         tick();
         if (meas_valid) begin
            pulses++;
            chk("to_period", period, 32'd100);
            chk("to_stall_sticky", 32'(stall), 32'd1);
         end
      end
      chk("to_pulses", 32'(pulses), 32'd3);

      // asynchronous reset in the middle of a cycle
      enable = 1'b0; tick();
      enable = 1'b1; sample = '0; tick();
      for (int i = 0; i < 180; i++) begin
         sample = sq(i);
         tick();
      end
      #3 rst_n = 1'b0;
      #1;
      chk("arst_period", period, 32'd0);
      chk("arst_minmax", {8'd0, min_val, max_val}, 32'd0);
      chk("arst_flags", {29'd0, meas_valid, done, stall}, 32'd0);
      chk("arst_cycle_count", 32'(cycle_count), 32'd0);
      #7 rst_n = 1'b1;
      sample = '0; tick();
      pulses = 0; first_idx = -1;
      for (int i = 0; i < 300; i++) begin
         sample = sq(i);
         tick();
         if (meas_valid) begin
            pulses++;
            if (first_idx < 0) first_idx = i;
         end
      end
      chk("arst_first_meas_idx", 32'(first_idx), 32'd150);
      chk("arst_pulses", 32'(pulses), 32'd2);
      chk("arst_cycle_count_after", 32'(cycle_count), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
